// File: rtl/valet_cmd_sequencer.sv
// Command sequencer in front of the CAM parking lot: buffers park/retrieve requests,
// screens each one with a lookup, issues at most one lot strobe, and returns a status.
module valet_cmd_sequencer #(
    parameter int TAG_WIDTH  = 16,
    parameter int DEPTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_op,
    input  logic [TAG_WIDTH-1:0]         req_tag,
    output logic                         cam_write_en,
    output logic                         cam_read_en,
    output logic [TAG_WIDTH-1:0]         cam_tag,
    input  logic                         cam_match_found,
    input  logic [$clog2(DEPTH)-1:0]     cam_match_index,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_op,
    output logic [TAG_WIDTH-1:0]         rsp_tag,
    output logic [1:0]                   rsp_status,
    output logic [$clog2(DEPTH)-1:0]     rsp_index,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_FULL      = 2'b01;
    localparam logic [1:0] ST_NOT_FOUND = 2'b10;
    localparam logic [1:0] ST_DUPLICATE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_EXEC,
        S_RESP
    } state_t;

    logic                 op_mem_q  [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 push, pop, fifo_empty;

    state_t               state_q, state_d;
    logic                 cmd_op_q, cmd_op_d;
    logic [TAG_WIDTH-1:0] cam_tag_q, cam_tag_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;
    logic [1:0]           status_q, status_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [OCC_W-1:0]     occ_q, occ_d;

    // Ready depends only on registered fullness, so a same-cycle pop never frees a slot.
    assign req_ready  = rst && (cnt_q != CNT_FULL);
    assign push       = req_valid && req_ready;
    assign fifo_empty = (cnt_q == '0);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q]  <= req_op;
            tag_mem_q[wr_ptr_q] <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // The screening decision is taken from the lookup result at the end of LOOKUP,
    // so the strobe and status are already registered while the FSM sits in EXEC.
    always_comb begin
        state_d   = state_q;
        cmd_op_d  = cmd_op_q;
        cam_tag_d = cam_tag_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        status_d  = status_q;
        index_d   = index_q;
        occ_d     = occ_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    cmd_op_d  = op_mem_q[rd_ptr_q];
                    cam_tag_d = tag_mem_q[rd_ptr_q];
                    state_d   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                index_d = '0;
                if (!cmd_op_q) begin
                    if (cam_match_found) begin
                        status_d = ST_DUPLICATE;
                        index_d  = cam_match_index;
                    end else if (occ_q == OCC_FULL) begin
                        status_d = ST_FULL;
                    end else begin
                        status_d = ST_OK;
                        wr_en_d  = 1'b1;
                    end
                end else begin
                    if (cam_match_found) begin
                        status_d = ST_OK;
                        index_d  = cam_match_index;
                        rd_en_d  = 1'b1;
                    end else begin
                        status_d = ST_NOT_FOUND;
                    end
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (wr_en_q && (occ_q != OCC_FULL)) occ_d = occ_q + 1'b1;
                if (rd_en_q && (occ_q != '0))       occ_d = occ_q - 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cmd_op_q  <= 1'b0;
            cam_tag_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            status_q  <= 2'b00;
            index_q   <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_op_q  <= cmd_op_d;
            cam_tag_q <= cam_tag_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            status_q  <= status_d;
            index_q   <= index_d;
            occ_q     <= occ_d;
        end
    end

    assign cam_write_en = wr_en_q;
    assign cam_read_en  = rd_en_q;
    assign cam_tag      = cam_tag_q;
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_op       = cmd_op_q;
    assign rsp_tag      = cam_tag_q;
    assign rsp_status   = status_q;
    assign rsp_index    = index_q;
    assign occupancy    = occ_q;

endmodule

// File: tb/tb_valet_cmd_sequencer.sv
// Bench for valet_cmd_sequencer: a small CAM lot model drives the match inputs;
// directed table vectors, hand-timed sequences and a randomized run against a reference.
module tb_valet_cmd_sequencer;

    localparam int TW = 16;
    localparam int DP = 8;
    localparam int FD = 4;
    localparam int IW = 3;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_op;
    logic [TW-1:0] req_tag;
    logic          cam_write_en, cam_read_en;
    logic [TW-1:0] cam_tag;
    logic          lot_hit;
    logic [IW-1:0] lot_idx;
    logic          rsp_valid, rsp_ready, rsp_op;
    logic [TW-1:0] rsp_tag;
    logic [1:0]    rsp_status;
    logic [IW-1:0] rsp_index;
    logic [OW-1:0] occupancy;

    int n_vec = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    always #5 clk = ~clk;

    valet_cmd_sequencer #(.TAG_WIDTH(TW), .DEPTH(DP), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
        .cam_write_en(cam_write_en), .cam_read_en(cam_read_en), .cam_tag(cam_tag),
        .cam_match_found(lot_hit), .cam_match_index(lot_idx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .rsp_status(rsp_status), .rsp_index(rsp_index), .occupancy(occupancy)
    );

    // Lot model: lowest free slot on park, combinational lookup on cam_tag.
    logic          lot_v   [DP];
    logic [TW-1:0] lot_tag [DP];
    logic          lot_has_free;
    logic [IW-1:0] lot_free;

    always_comb begin
        lot_hit = 1'b0;
        lot_idx = '0;
        lot_has_free = 1'b0;
        lot_free = '0;
        for (int i = 0; i < DP; i++) begin
            if (!lot_hit && lot_v[i] === 1'b1 && lot_tag[i] == cam_tag) begin
                lot_hit = 1'b1;
                lot_idx = IW'(i);
            end
            if (!lot_has_free && lot_v[i] !== 1'b1) begin
                lot_has_free = 1'b1;
                lot_free = IW'(i);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DP; i++) lot_v[i] <= 1'b0;
        end else begin
            if (cam_write_en && lot_has_free) begin
                lot_v[lot_free]   <= 1'b1;
                lot_tag[lot_free] <= cam_tag;
            end
            if (cam_read_en && lot_hit) lot_v[lot_idx] <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (cam_write_en) wr_cnt++;
            if (cam_read_en)  rd_cnt++;
            if (cam_write_en || cam_read_en)
                chk("one_strobe", 32'(cam_write_en && cam_read_en), 32'd0);
        end
    end

    // Reference: parked cars as a slot table, evaluated in request order.
    typedef struct {
        logic          op;
        logic [TW-1:0] tag;
        logic [1:0]    st;
        logic [IW-1:0] idx;
        int            occ;
        int            wr;
        int            rd;
    } exp_t;

    logic          ref_v   [DP];
    logic [TW-1:0] ref_tag [DP];

    task automatic ref_clear();
        for (int i = 0; i < DP; i++) ref_v[i] = 1'b0;
    endtask

    task automatic ref_apply(input logic op, input logic [TW-1:0] tag, output exp_t e);
        int hit, freei, cnt;
        hit = -1; freei = -1; cnt = 0;
        for (int i = DP - 1; i >= 0; i--) begin
            if (ref_v[i]) begin
                cnt++;
                if (ref_tag[i] == tag) hit = i;
            end else freei = i;
        end
        e.op = op; e.tag = tag; e.idx = '0; e.wr = 0; e.rd = 0;
        if (!op) begin
            if (hit >= 0)        begin e.st = 2'b11; e.idx = IW'(hit); end
            else if (cnt == DP)  e.st = 2'b01;
            else begin
                e.st = 2'b00; e.wr = 1; cnt++;
                ref_v[freei] = 1'b1; ref_tag[freei] = tag;
            end
        end else begin
            if (hit < 0) e.st = 2'b10;
            else begin
                e.st = 2'b00; e.idx = IW'(hit); e.rd = 1; cnt--;
                ref_v[hit] = 1'b0;
            end
        end
        e.occ = cnt;
    endtask

    task automatic do_reset(input bit full_chk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        if (full_chk) begin
            chk("rst_write_en", 32'(cam_write_en), 32'd0);
            chk("rst_read_en", 32'(cam_read_en), 32'd0);
            chk("rst_cam_tag", 32'(cam_tag), 32'd0);
            chk("rst_rsp_op", 32'(rsp_op), 32'd0);
            chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
            chk("rst_rsp_status", 32'(rsp_status), 32'd0);
            chk("rst_rsp_index", 32'(rsp_index), 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        ref_clear();
    endtask

    task automatic send(input logic op, input logic [TW-1:0] tag);
        int n;
        n = 0;
        req_op = op; req_tag = tag; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic g_op, output logic [TW-1:0] g_tag,
                           output logic [1:0] g_st, output logic [IW-1:0] g_idx,
                           output int g_occ);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", 32'(n < 50), 32'd1);
        g_op = rsp_op; g_tag = rsp_tag; g_st = rsp_status; g_idx = rsp_index;
        g_occ = int'(occupancy);
        @(negedge clk);
    endtask

    int wr_base, rd_base, cum_wr, cum_rd;

    task automatic cmp_rsp(input exp_t e);
        cum_wr += e.wr;
        cum_rd += e.rd;
        chk("rnd_op", 32'(rsp_op), 32'(e.op));
        chk("rnd_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rnd_status", 32'(rsp_status), 32'(e.st));
        chk("rnd_index", 32'(rsp_index), 32'(e.idx));
        chk("rnd_occupancy", 32'(occupancy), 32'(e.occ));
        chk("rnd_write_strobes", 32'(wr_cnt - wr_base), 32'(cum_wr));
        chk("rnd_read_strobes", 32'(rd_cnt - rd_base), 32'(cum_rd));
    endtask

    typedef struct {
        bit            rst_first;
        logic          op;
        logic [TW-1:0] tag;
        logic [1:0]    st;
        logic [IW-1:0] idx;
        int            occ;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic          g_op;
        logic [TW-1:0] g_tag;
        logic [1:0]    g_st;
        logic [IW-1:0] g_idx;
        int            g_occ, w0, r0, acc, seen;
        exp_t          q [$];
        exp_t          e;

        rst = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_tag = '0; rsp_ready = 1'b1;

        tbl[0] = '{1'b0, 1'b0, 16'h1234, 2'b11, 3'd0, 1};
        tbl[1] = '{1'b1, 1'b0, 16'h0001, 2'b00, 3'd0, 1};
        for (int k = 2; k <= 8; k++) tbl[k] = '{1'b0, 1'b0, 16'(k), 2'b00, 3'd0, k};
        tbl[9]  = '{1'b0, 1'b0, 16'h0009, 2'b01, 3'd0, 8};
        tbl[10] = '{1'b0, 1'b0, 16'h0003, 2'b11, 3'd2, 8};
        tbl[11] = '{1'b0, 1'b1, 16'h0005, 2'b00, 3'd4, 7};
        tbl[12] = '{1'b0, 1'b1, 16'hBEEF, 2'b10, 3'd0, 7};
        tbl[13] = '{1'b0, 1'b1, 16'h0005, 2'b10, 3'd0, 7};
        tbl[14] = '{1'b0, 1'b0, 16'h0009, 2'b00, 3'd0, 8};
        tbl[15] = '{1'b0, 1'b1, 16'h0009, 2'b00, 3'd4, 7};

        do_reset(1'b1);

        // First park, cycle-exact: push edge, pop, LOOKUP, EXEC strobe, RESP.
        req_op = 1'b0; req_tag = 16'h1234; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t1_we_idle", 32'(cam_write_en), 32'd0);
        @(negedge clk);
        chk("t1_we_lookup", 32'(cam_write_en), 32'd0);
        chk("t1_cam_tag", 32'(cam_tag), 32'h1234);
        @(negedge clk);
        chk("t1_we_exec", 32'(cam_write_en), 32'd1);
        chk("t1_re_exec", 32'(cam_read_en), 32'd0);
        chk("t1_valid_exec", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_we_resp", 32'(cam_write_en), 32'd0);
        chk("t1_valid_resp", 32'(rsp_valid), 32'd1);
        chk("t1_status", 32'(rsp_status), 32'd0);
        chk("t1_occupancy", 32'(occupancy), 32'd1);
        @(negedge clk);
        chk("t1_valid_after", 32'(rsp_valid), 32'd0);

        for (int v = 0; v < 16; v++) begin
            if (tbl[v].rst_first) do_reset(1'b0);
            w0 = wr_cnt; r0 = rd_cnt;
            send(tbl[v].op, tbl[v].tag);
            get_rsp(g_op, g_tag, g_st, g_idx, g_occ);
            chk($sformatf("v%0d_status", v), 32'(g_st), 32'(tbl[v].st));
            chk($sformatf("v%0d_index", v), 32'(g_idx), 32'(tbl[v].idx));
            chk($sformatf("v%0d_tag", v), 32'(g_tag), 32'(tbl[v].tag));
            chk($sformatf("v%0d_op", v), 32'(g_op), 32'(tbl[v].op));
            chk($sformatf("v%0d_occupancy", v), 32'(g_occ), 32'(tbl[v].occ));
            chk($sformatf("v%0d_write_strobes", v), 32'(wr_cnt - w0),
                32'(!tbl[v].op && tbl[v].st == 2'b00));
            chk($sformatf("v%0d_read_strobes", v), 32'(rd_cnt - r0),
                32'(tbl[v].op && tbl[v].st == 2'b00));
        end

        // Backpressure: FIFO_DEPTH entries plus one in flight, then drain in order.
        do_reset(1'b0);
        rsp_ready = 1'b0;
        acc = 0;
        req_op = 1'b0; req_tag = 16'hA000; req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (req_ready) acc++;
            @(negedge clk);
            req_tag = 16'hA000 + 16'(acc);
        end
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
        chk("bp_rsp_tag_held", 32'(rsp_tag), 32'hA000);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            get_rsp(g_op, g_tag, g_st, g_idx, g_occ);
            chk($sformatf("bp_tag%0d", k), 32'(g_tag), 32'hA000 + 32'(k));
            chk($sformatf("bp_status%0d", k), 32'(g_st), 32'd0);
        end

        // Reset while a park sits in EXEC.
        do_reset(1'b0);
        send(1'b0, 16'h7777);
        seen = 0;
        while (!cam_write_en && seen < 10) begin
            @(negedge clk);
            seen++;
        end
        chk("mid_exec_reached", 32'(cam_write_en), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_we", 32'(cam_write_en), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_occupancy", 32'(occupancy), 32'd0);
        rst = 1'b1;
        ref_clear();
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mid_no_response", 32'(seen), 32'd0);
        send(1'b0, 16'h7777);
        get_rsp(g_op, g_tag, g_st, g_idx, g_occ);
        chk("mid_repark_status", 32'(g_st), 32'd0);
        chk("mid_repark_occupancy", 32'(g_occ), 32'd1);

        // Randomized traffic with random backpressure against the reference.
        do_reset(1'b0);
        wr_base = wr_cnt; rd_base = rd_cnt; cum_wr = 0; cum_rd = 0;
        for (int c = 0; c < 1500; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = ($urandom_range(0, 2) == 0);
            req_op    = ($urandom_range(0, 2) == 0);
            req_tag   = 16'h0100 + 16'($urandom_range(0, 11));
            if (req_valid && req_ready) begin
                ref_apply(req_op, req_tag, e);
                q.push_back(e);
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) chk("rnd_unexpected_rsp", 32'd1, 32'd0);
                else cmp_rsp(q.pop_front());
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && q.size() > 0; c++) begin
            if (rsp_valid) cmp_rsp(q.pop_front());
            @(negedge clk);
        end
        chk("rnd_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
